cook_sequencer: RTL and testbench
=================================

// Module: cook_sequencer
// PURPOSE
//  Top-level sequencer for the microwave timer datapath. Takes BCD digits and the
//  loadn strobe from the keypad/timer-control block, assembles an MM:SS setpoint,
//  counts it down on the 1 Hz pulse and drives magnetron enable and the done alarm.
//  It also drives enablen back to the timer-control block, gating keypad entry.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop depth of the input synchronizers (>=2)
//  DONE_TICKS   3  number of 1 Hz ticks that done stays high after countdown ends
// PORTS
//  clk          in   1  system clock; all state on posedge clk
//  clearn       in   1  asynchronous, active-low reset
//  d            in   4  BCD digit from the keypad encoder; valid while loadn=0
//  loadn        in   1  keypress strobe, active-low
//  pgt_1Hz      in   1  1 Hz square/pulse; rising edge = one countdown tick
//  startn       in   1  start button, active-low, asynchronous
//  stopn        in   1  stop/cancel button, active-low, asynchronous
//  door_closed  in   1  1 = door closed, asynchronous
//  enablen      out  1  0 = keypad entry enabled (IDLE/DONE), 1 otherwise
//  min_tens     out  4  BCD display digits, MM:SS
//  min_units    out  4
//  sec_tens     out  4
//  sec_units    out  4
//  mag_on       out  1  magnetron enable; 1 only in COOKING with door closed
//  done         out  1  alarm; 1 in DONE
// BEHAVIOUR
//  - Reset (clearn=0, async): state=IDLE, all digits=0, mag_on=0, done=0, enablen=0.
//  - Inputs loadn, pgt_1Hz, startn, stopn and door_closed pass SYNC_STAGES FFs.
//    Events are edges of the synchronized signals: key=fall(loadn), tick=rise(pgt_1Hz),
//    start=fall(startn), stop=fall(stopn). Each event fires once per edge, never on
//    level. With SYNC_STAGES=2, outputs react on the 3rd posedge after an input change.
//  - d is sampled in the cycle key is detected. Codes >9 are ignored: no shift.
//  - States: IDLE, COOKING, PAUSED, DONE. Priority within a cycle: stop > door > start > tick > key.
//  - IDLE: key shifts the digits left: min_tens<=min_units, min_units<=sec_tens,
//    sec_tens<=sec_units, sec_units<=d. The oldest digit is lost.
//    - start with door_closed=1 and digits!=0000 -> COOKING.
//    - start with digits=0000 or door open: ignored.
//    - stop clears the digits to 0000.
//  - COOKING: mag_on=1.
//    - stop -> PAUSED.
//    - door_closed=0 -> PAUSED; mag_on falls in the same cycle the state changes.
//    - tick decrements MM:SS in BCD:
//      - sec_units 0->9 borrows from sec_tens.
//      - sec_tens 0 with borrow -> 5, borrowing from the minutes.
//      - min_units 0->9 borrows from min_tens.
//    - Entered seconds tens >5 (e.g. 90) count down normally, with no normalisation.
//    - A tick that makes the value 0000 -> DONE in the same cycle.
//    - key is ignored.
//  - PAUSED: digits hold, mag_on=0.
//    - start with door_closed=1 -> COOKING.
//    - stop -> IDLE with digits cleared.
//    - tick and key are ignored.
//  - DONE: done=1, mag_on=0, digits=0000.
//    - Return to IDLE after DONE_TICKS ticks, or immediately on stop or key.
//    - A key that exits DONE is not shifted in.
//  - enablen=1 in COOKING and PAUSED, 0 in IDLE and DONE.
//  - All outputs are registered; there are no combinational paths from inputs to outputs.
//  - Reset mid-operation returns to the reset values at once; nothing is retained.
// TESTING
//  1 reset, keys 1,3,0 -> digits 01:30, enablen=0; start -> COOKING, mag_on=1, enablen=1
//  2 setpoint 01:00, COOKING, 1 tick -> 00:59; 59 more ticks -> DONE, done=1, mag_on=0,
//    back to IDLE after 3 ticks
//  3 COOKING at 00:10, door_closed=0 -> PAUSED, mag_on=0; ticks hold 00:10;
//    door closed + start -> COOKING, next tick 00:09
//  4 IDLE 0000, start -> stays IDLE; key d=4'hA -> digits unchanged; 5 keys 1..5 -> 23:45
//  5 same-cycle stop+start and stop+tick while COOKING at 00:05 -> PAUSED, value 00:05;
//    second stop -> IDLE, 0000
//  6 assert clearn low mid-COOKING at 02:17 -> IDLE, 0000, mag_on=0 immediately (async)

Source files
------------

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: assembles an MM:SS setpoint from keypad digits, counts it down
// on the 1 Hz tick and drives the magnetron enable, the done alarm and keypad gating.
module cook_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DONE_TICKS  = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] d,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enablen,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       mag_on,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, COOKING, PAUSED, DONE} state_t;

    localparam logic [7:0] DONE_LAST = 8'(DONE_TICKS - 1);

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] loadn_sync, tick_sync, startn_sync, stopn_sync, door_sync;
    logic loadn_prev, tick_prev, startn_prev, stopn_prev;
    logic key_evt, tick_evt, start_evt, stop_evt, door_s;

    logic [15:0] digits_q, digits_nxt, digits_dec;
    logic [7:0]  done_cnt, done_cnt_nxt;

    // One BCD tick off MM:SS; seconds tens wrap to 5, units to 9.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mu, st, su;
        logic       borrow;
        {mt, mu, st, su} = v;
        borrow = (su == 4'd0);
        su     = borrow ? 4'd9 : su - 4'd1;
        if (borrow) begin
            borrow = (st == 4'd0);
            st     = borrow ? 4'd5 : st - 4'd1;
        end
        if (borrow) begin
            borrow = (mu == 4'd0);
            mu     = borrow ? 4'd9 : mu - 4'd1;
        end
        if (borrow) begin
            mt = mt - 4'd1;
        end
        return {mt, mu, st, su};
    endfunction

    // Synchronizer chains plus one extra flop per event input for edge detection
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            loadn_sync  <= '1;
            tick_sync   <= '0;
            startn_sync <= '1;
            stopn_sync  <= '1;
            door_sync   <= '0;
            loadn_prev  <= 1'b1;
            tick_prev   <= 1'b0;
            startn_prev <= 1'b1;
            stopn_prev  <= 1'b1;
        end else begin
            loadn_sync  <= {loadn_sync[SYNC_STAGES-2:0], loadn};
            tick_sync   <= {tick_sync[SYNC_STAGES-2:0], pgt_1Hz};
            startn_sync <= {startn_sync[SYNC_STAGES-2:0], startn};
            stopn_sync  <= {stopn_sync[SYNC_STAGES-2:0], stopn};
            door_sync   <= {door_sync[SYNC_STAGES-2:0], door_closed};
            loadn_prev  <= loadn_sync[SYNC_STAGES-1];
            tick_prev   <= tick_sync[SYNC_STAGES-1];
            startn_prev <= startn_sync[SYNC_STAGES-1];
            stopn_prev  <= stopn_sync[SYNC_STAGES-1];
        end
    end

    assign key_evt    = loadn_prev & ~loadn_sync[SYNC_STAGES-1];
    assign tick_evt   = ~tick_prev & tick_sync[SYNC_STAGES-1];
    assign start_evt  = startn_prev & ~startn_sync[SYNC_STAGES-1];
    assign stop_evt   = stopn_prev & ~stopn_sync[SYNC_STAGES-1];
    assign door_s     = door_sync[SYNC_STAGES-1];
    assign digits_dec = bcd_dec(digits_q);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state    <= IDLE;
            digits_q <= '0;
            done_cnt <= '0;
            mag_on   <= 1'b0;
            done     <= 1'b0;
            enablen  <= 1'b0;
        end else begin
            state    <= state_nxt;
            digits_q <= digits_nxt;
            done_cnt <= done_cnt_nxt;
            mag_on   <= (state_nxt == COOKING);
            done     <= (state_nxt == DONE);
            enablen  <= (state_nxt == COOKING) || (state_nxt == PAUSED);
        end
    end

    // Event priority: stop > door > start > tick > key
    always_comb begin
        state_nxt    = state;
        digits_nxt   = digits_q;
        done_cnt_nxt = done_cnt;
        unique case (state)
            IDLE: begin
                if (stop_evt) begin
                    digits_nxt = '0;
                end else if (start_evt) begin
                    if (door_s && (digits_q != '0)) state_nxt = COOKING;
                end else if (key_evt && (d <= 4'd9)) begin
                    digits_nxt = {digits_q[11:0], d};
                end
            end
            COOKING: begin
                if (stop_evt || !door_s) begin
                    state_nxt = PAUSED;
                end else if (tick_evt) begin
                    digits_nxt = digits_dec;
                    if (digits_dec == '0) begin
                        state_nxt    = DONE;
                        done_cnt_nxt = '0;
                    end
                end
            end
            PAUSED: begin
                if (stop_evt) begin
                    state_nxt  = IDLE;
                    digits_nxt = '0;
                end else if (start_evt && door_s) begin
                    state_nxt = COOKING;
                end
            end
            DONE: begin
                digits_nxt = '0;
                if (stop_evt || key_evt) begin
                    state_nxt = IDLE;
                end else if (tick_evt) begin
                    if (done_cnt == DONE_LAST) state_nxt = IDLE;
                    else                       done_cnt_nxt = done_cnt + 8'd1;
                end
            end
        endcase
    end

    assign {min_tens, min_units, sec_tens, sec_units} = digits_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed scenarios plus a random event stream, all checked
// against a model that keeps the setpoint as a plain decimal number.
module tb_cook_sequencer;

    logic       clk = 1'b0;
    logic       clearn, loadn, pgt_1Hz, startn, stopn, door_closed;
    logic [3:0] d;
    logic       enablen, mag_on, done;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic [18:0] obs;

    int errors = 0;
    int checks = 0;

    localparam int S_IDLE = 0, S_COOK = 1, S_PAUSE = 2, S_DONE = 3;
    int m_state, m_n, m_cnt;
    bit m_door;

    always #5 clk = ~clk;

    cook_sequencer #(.SYNC_STAGES(2), .DONE_TICKS(3)) dut (
        .clk(clk), .clearn(clearn), .d(d), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
        .startn(startn), .stopn(stopn), .door_closed(door_closed), .enablen(enablen),
        .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
        .sec_units(sec_units), .mag_on(mag_on), .done(done)
    );

    assign obs = {enablen, mag_on, done, min_tens, min_units, sec_tens, sec_units};

    // Setpoint held as a 4-digit decimal number MMSS
    function automatic logic [18:0] model_out();
        int mm, ss;
        mm = m_n / 100;
        ss = m_n % 100;
        return {(m_state == S_COOK || m_state == S_PAUSE), (m_state == S_COOK),
                (m_state == S_DONE), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_apply(input bit stp, input bit st, input bit tk, input bit ky, input int dv);
        case (m_state)
            S_IDLE: begin
                if (stp) m_n = 0;
                else if (st) begin
                    if (m_door && m_n != 0) m_state = S_COOK;
                end else if (ky && dv <= 9) m_n = (m_n * 10 + dv) % 10000;
            end
            S_COOK: begin
                if (stp || !m_door) m_state = S_PAUSE;
                else if (tk) begin
                    m_n = (m_n % 100 == 0) ? m_n - 41 : m_n - 1;
                    if (m_n == 0) begin
                        m_state = S_DONE;
                        m_cnt = 0;
                    end
                end
            end
            S_PAUSE: begin
                if (stp) begin
                    m_state = S_IDLE;
                    m_n = 0;
                end else if (st && m_door) m_state = S_COOK;
            end
            default: begin
                if (stp || ky) m_state = S_IDLE;
                else if (tk) begin
                    m_cnt++;
                    if (m_cnt == 3) m_state = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit stp, input bit st, input bit tk, input bit ky, input logic [3:0] dv);
        d = dv;
        if (stp) stopn = 1'b0;
        if (st) startn = 1'b0;
        if (tk) pgt_1Hz = 1'b1;
        if (ky) loadn = 1'b0;
        cyc(4);
        stopn = 1'b1; startn = 1'b1; pgt_1Hz = 1'b0; loadn = 1'b1;
        cyc(4);
        model_apply(stp, st, tk, ky, int'(dv));
    endtask

    task automatic set_door(input bit v);
        door_closed = v;
        cyc(4);
        m_door = v;
        model_apply(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        clearn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1; stopn = 1'b1; d = 4'd0;
        cyc(2);
        clearn = 1'b1;
        cyc(4);
        m_state = S_IDLE; m_n = 0; m_cnt = 0; m_door = door_closed;
    endtask

    task automatic test_reset();
        clearn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1; stopn = 1'b1;
        d = 4'd0; door_closed = 1'b1;
        #1;
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL reset_now got %h exp %h", obs, 19'h0); end
        cyc(3);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL reset_held got %h exp %h", obs, 19'h0); end
        do_reset();
    endtask

    task automatic test_keys_start();
        do_reset();
        d = 4'd1; loadn = 1'b0;
        cyc(2);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL key_latency_early got %h exp %h", obs, 19'h0); end
        cyc(1);
        checks++;
        if (obs !== 19'h00001) begin errors++; $display("FAIL key_latency_3rd got %h exp %h", obs, 19'h00001); end
        cyc(1); loadn = 1'b1; cyc(4);
        model_apply(1'b0, 1'b0, 1'b0, 1'b1, 1);
        pulse(0, 0, 0, 1, 4'd3);
        pulse(0, 0, 0, 1, 4'd0);
        checks++;
        if (obs !== 19'h00130) begin errors++; $display("FAIL keys_0130 got %h exp %h", obs, 19'h00130); end
        pulse(0, 1, 0, 0, 4'd0);
        checks++;
        if (obs !== {3'b110, 16'h0130}) begin errors++; $display("FAIL start_cook got %h exp %h", obs, {3'b110, 16'h0130}); end
    endtask

    task automatic test_countdown_done();
        do_reset();
        pulse(0, 0, 0, 1, 4'd1); pulse(0, 0, 0, 1, 4'd0); pulse(0, 0, 0, 1, 4'd0);
        pulse(0, 1, 0, 0, 4'd0);
        pulse(0, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== {3'b110, 16'h0059}) begin errors++; $display("FAIL tick_0059 got %h exp %h", obs, {3'b110, 16'h0059}); end
        for (int i = 0; i < 59; i++) pulse(0, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== {3'b001, 16'h0000}) begin errors++; $display("FAIL reach_done got %h exp %h", obs, {3'b001, 16'h0000}); end
        pulse(0, 0, 1, 0, 4'd0); pulse(0, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== model_out()) begin errors++; $display("FAIL done_hold got %h exp %h", obs, model_out()); end
        pulse(0, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL done_to_idle got %h exp %h", obs, 19'h0); end
    endtask

    task automatic test_door_pause();
        do_reset();
        pulse(0, 0, 0, 1, 4'd1); pulse(0, 0, 0, 1, 4'd0);
        pulse(0, 1, 0, 0, 4'd0);
        set_door(1'b0);
        checks++;
        if (obs !== {3'b100, 16'h0010}) begin errors++; $display("FAIL door_pause got %h exp %h", obs, {3'b100, 16'h0010}); end
        pulse(0, 0, 1, 0, 4'd0); pulse(0, 0, 1, 0, 4'd0);
        pulse(0, 1, 0, 0, 4'd0);
        checks++;
        if (obs !== {3'b100, 16'h0010}) begin errors++; $display("FAIL paused_hold got %h exp %h", obs, {3'b100, 16'h0010}); end
        set_door(1'b1);
        pulse(0, 1, 0, 0, 4'd0);
        pulse(0, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== {3'b110, 16'h0009}) begin errors++; $display("FAIL resume_tick got %h exp %h", obs, {3'b110, 16'h0009}); end
    endtask

    task automatic test_idle_ignores();
        do_reset();
        pulse(0, 1, 0, 0, 4'd0);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL start_on_zero got %h exp %h", obs, 19'h0); end
        pulse(0, 0, 0, 1, 4'hA);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL key_invalid got %h exp %h", obs, 19'h0); end
        for (int k = 1; k <= 5; k++) pulse(0, 0, 0, 1, 4'(k));
        checks++;
        if (obs !== 19'h02345) begin errors++; $display("FAIL five_keys got %h exp %h", obs, 19'h02345); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pulse(0, 0, 0, 1, 4'd5);
        pulse(0, 1, 0, 0, 4'd0);
        pulse(1, 1, 0, 0, 4'd0);
        checks++;
        if (obs !== {3'b100, 16'h0005}) begin errors++; $display("FAIL stop_start got %h exp %h", obs, {3'b100, 16'h0005}); end
        pulse(0, 1, 0, 0, 4'd0);
        pulse(1, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== {3'b100, 16'h0005}) begin errors++; $display("FAIL stop_tick got %h exp %h", obs, {3'b100, 16'h0005}); end
        pulse(1, 0, 0, 0, 4'd0);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL second_stop got %h exp %h", obs, 19'h0); end
    endtask

    task automatic test_done_exit();
        do_reset();
        pulse(0, 0, 0, 1, 4'd9); pulse(0, 0, 0, 1, 4'd0);
        pulse(0, 1, 0, 0, 4'd0);
        pulse(0, 0, 1, 0, 4'd0);
        checks++;
        if (obs !== {3'b110, 16'h0089}) begin errors++; $display("FAIL secs_90 got %h exp %h", obs, {3'b110, 16'h0089}); end
        pulse(1, 0, 0, 0, 4'd0); pulse(1, 0, 0, 0, 4'd0);
        pulse(0, 0, 0, 1, 4'd1);
        pulse(0, 1, 0, 0, 4'd0);
        pulse(0, 0, 1, 0, 4'd0);
        pulse(0, 0, 0, 1, 4'd7);
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL key_exit_done got %h exp %h", obs, 19'h0); end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse(0, 0, 0, 1, 4'd2); pulse(0, 0, 0, 1, 4'd1); pulse(0, 0, 0, 1, 4'd7);
        pulse(0, 1, 0, 0, 4'd0);
        checks++;
        if (obs !== {3'b110, 16'h0217}) begin errors++; $display("FAIL cook_0217 got %h exp %h", obs, {3'b110, 16'h0217}); end
        @(posedge clk);
        #2 clearn = 1'b0;
        #1;
        checks++;
        if (obs !== 19'h0) begin errors++; $display("FAIL async_reset got %h exp %h", obs, 19'h0); end
        cyc(2);
        do_reset();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      pulse(0, 0, 0, 1, 4'($urandom_range(0, 15)));
            else if (r <= 5) pulse(0, 0, 1, 0, 4'd0);
            else if (r == 6) pulse(0, 1, 0, 0, 4'd0);
            else if (r == 7) pulse(1, 0, 0, 0, 4'd0);
            else if (r == 8) set_door(~door_closed);
            else             set_door(1'b1);
            checks++;
            if (obs !== model_out()) begin
                errors++;
                $display("FAIL random_step%0d got %h exp %h", i, obs, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_keys_start();
        test_countdown_done();
        test_door_pause();
        test_idle_ignores();
        test_same_cycle();
        test_done_exit();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
